// File: rtl/bus_bridge.sv
// Single-outstanding bridge from the CPU request/ack port to a memory port
// with ready handshake and a per-access timeout abort.
module bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [16:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  bus_in,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a cpu_req seen in IDLE is accepted on that edge; cpu_busy is
  // high until the one-cycle cpu_ack (with cpu_err on abort), and requests
  // during busy are dropped. mem_req stays high until mem_ready or timeout.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 17'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // A ready arriving on the last allowed cycle still completes cleanly.
        if (mem_ready) begin
          state_d = S_RESP;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          if (!we_q) rdata_d = 8'hFF;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req     = (state_q == S_ACCESS);
  assign cpu_ack     = (state_q == S_RESP);
  assign cpu_err     = (state_q == S_RESP) && err_q;
  assign cpu_busy    = (state_q != S_IDLE);
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign bus_in      = rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed cases plus random transactions
// compared against a transaction-level model of latency, error and read data.
module tb_bus_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_in;
  logic        cpu_ack, cpu_err, cpu_busy;
  logic        mem_req, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_bus;
  logic [8:0] exp_q[$];

  bus_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .bus_in(bus_in), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Starts at a negedge in IDLE and ends at the negedge of the IDLE cycle
  // after cpu_ack, so consecutive calls issue back-to-back requests.
  task automatic run_txn(input logic we, input logic [16:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata,
                         input int delay, input bit inject);
    logic       exp_err;
    logic [8:0] exp_entry;
    int         exp_cyc;
    int         cyc;
    exp_err = (delay >= TO);
    exp_cyc = exp_err ? TO : delay + 1;
    if (!we) exp_bus = exp_err ? 8'hFF : rdata;
    exp_q.push_back({exp_err, exp_bus});

    checks++;
    if (cpu_busy !== 1'b0) begin
      errors++; $display("FAIL idle_before_req: cpu_busy=%b expected 0", cpu_busy);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = $urandom; cpu_addr = 17'($urandom); cpu_wdata = 8'($urandom);

    cyc = 0;
    while (mem_req === 1'b1 && cyc < TO + 4) begin
      checks++;
      if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) begin
        errors++;
        $display("FAIL access_latch: addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                 mem_addr, mem_we, mem_wdata, addr, we, wdata);
      end
      checks++;
      if (cpu_busy !== 1'b1 || cpu_ack !== 1'b0 || cpu_err !== 1'b0) begin
        errors++;
        $display("FAIL access_flags: busy=%b ack=%b err=%b expected 1 0 0", cpu_busy, cpu_ack, cpu_err);
      end
      if (inject && cyc == 1) begin
        cpu_req = 1'b1; cpu_addr = 17'h1_FFFF; cpu_we = ~we;
      end else begin
        cpu_req = 1'b0;
      end
      mem_ready = (cyc == delay);
      mem_rdata = (cyc == delay) ? rdata : 8'($urandom);
      cyc++;
      @(negedge clk);
    end
    mem_ready = 1'b0; cpu_req = 1'b0;

    checks++;
    if (cyc != exp_cyc) begin
      errors++; $display("FAIL mem_req_cycles: got %0d expected %0d", cyc, exp_cyc);
    end
    exp_entry = exp_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== exp_entry[8] || bus_in !== exp_entry[7:0]) begin
      errors++;
      $display("FAIL resp: ack=%b err=%b bus_in=%h expected ack=1 err=%b bus_in=%h",
               cpu_ack, cpu_err, bus_in, exp_entry[8], exp_entry[7:0]);
    end
    checks++;
    if (mem_req !== 1'b0 || cpu_busy !== 1'b1) begin
      errors++; $display("FAIL resp_flags: mem_req=%b busy=%b expected 0 1", mem_req, cpu_busy);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0 || bus_in !== exp_bus) begin
      errors++;
      $display("FAIL after_resp: ack=%b busy=%b bus_in=%h expected 0 0 %h", cpu_ack, cpu_busy, bus_in, exp_bus);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_bus = 8'h00;
    #3;
    checks++;
    if (bus_in !== 8'h00 || mem_addr !== 17'h0 || mem_wdata !== 8'h00 || mem_we !== 1'b0 ||
        cpu_ack !== 1'b0 || cpu_err !== 1'b0 || cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: bus_in=%h addr=%h wdata=%h we=%b ack=%b err=%b busy=%b req=%b expected all 0",
               bus_in, mem_addr, mem_wdata, mem_we, cpu_ack, cpu_err, cpu_busy, mem_req);
    end
    cpu_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_hold: busy=%b mem_req=%b expected 0 0", cpu_busy, mem_req);
    end
    cpu_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_txn(1'b0, 17'h1_2345, 8'h00, 8'hA5, 0, 1'b0);
    run_txn(1'b1, 17'h0_0010, 8'h3C, 8'h00, 3, 1'b0);
    run_txn(1'b0, 17'h0_4444, 8'h00, 8'h11, TO + 10, 1'b0);
    run_txn(1'b0, 17'h0_0777, 8'h00, 8'h5A, TO - 1, 1'b0);
    run_txn(1'b1, 17'h1_0001, 8'h99, 8'h00, TO + 10, 1'b0);
  endtask

  task automatic test_ignore_busy_req();
    run_txn(1'b0, 17'h0_0ABC, 8'h00, 8'hC3, 3, 1'b1);
    checks++;
    if (cpu_busy !== 1'b0 || mem_addr !== 17'h0_0ABC) begin
      errors++; $display("FAIL busy_req_queued: busy=%b mem_addr=%h expected 0 0abc", cpu_busy, mem_addr);
    end
  endtask

  task automatic test_idle_ready_ignored();
    for (int i = 0; i < 6; i++) begin
      mem_ready = $urandom; mem_rdata = 8'($urandom);
      @(negedge clk);
      checks++;
      if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || bus_in !== exp_bus) begin
        errors++;
        $display("FAIL idle_ready: busy=%b ack=%b bus_in=%h expected 0 0 %h", cpu_busy, cpu_ack, bus_in, exp_bus);
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h0_1357;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL second_access_cycle: mem_req=%b expected 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mem_req=%b busy=%b ack=%b expected 0 0 0", mem_req, cpu_busy, cpu_ack);
    end
    exp_bus = 8'h00;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (cpu_ack !== 1'b0 || cpu_err !== 1'b0 || bus_in !== 8'h00) begin
        errors++; $display("FAIL reset_no_ack: ack=%b err=%b bus_in=%h expected 0 0 00", cpu_ack, cpu_err, bus_in);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 17'h0_2468, 8'h00, 8'h77, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom), 17'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, TO + 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) test_idle_ready_ignored();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy_req();
    test_idle_ready_ignored();
    test_reset_mid_access();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
